// File: rtl/double_simd_threshold_if.sv
// Streaming handshake bundle for the SIMD threshold engine:
// one input beat channel and one output beat channel with row/frame markers.
interface double_simd_threshold_if #(
  parameter int SIMD_WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [8*SIMD_WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*SIMD_WIDTH-1:0] out_data;
  logic                    out_eol;
  logic                    out_eof;

  // Upstream loader / downstream writeback side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_eol, out_eof
  );

  // Threshold engine side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_eol, out_eof
  );
endinterface

// File: rtl/double_simd_threshold.sv
// Streaming SIMD binary-threshold engine for 8-bit grayscale frames.
// Each accepted beat of SIMD_WIDTH pixels is registered as 255/0 per lane
// (pixel > THRESHOLD), with row/frame position tracking and a done flag.
module double_simd_threshold #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int SIMD_WIDTH = 4,
  parameter int THRESHOLD  = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  double_simd_threshold_if.slave  bus
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic                    accept;
  logic                    last_col;
  logic                    last_row;
  logic [8*SIMD_WIDTH-1:0] thr_data;

  // A new beat may enter whenever the single output slot is empty or draining.
  assign bus.in_ready = busy & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign last_col     = (col == COL_W'(WIDTH - SIMD_WIDTH));
  assign last_row     = (row == ROW_W'(HEIGHT - 1));

  // Per-lane unsigned compare against the threshold.
  always_comb begin
    // NOTE: default assignment first so no path leaves thr_data unassigned (no latch).
    thr_data = '0;
    for (int k = 0; k < SIMD_WIDTH; k++) begin
      thr_data[8*k +: 8] = (bus.in_data[8*k +: 8] > 8'(THRESHOLD)) ? 8'hFF : 8'h00;
    end
  end

  // Frame control, position counters and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      busy          <= 1'b0;
      done          <= 1'b0;
      col           <= '0;
      row           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
    end else begin
      // Last beat has left the engine: frame is complete.
      if (bus.out_valid && bus.out_ready && bus.out_eof) begin
        done <= 1'b1;
      end

      // A start while a frame is running is ignored.
      if (start && !busy) begin
        busy <= 1'b1;
        done <= 1'b0;
        col  <= '0;
        row  <= '0;
      end

      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= thr_data;
        bus.out_eol   <= last_col;
        bus.out_eof   <= last_col & last_row;
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row  <= '0;
            busy <= 1'b0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + COL_W'(SIMD_WIDTH);
        end
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_double_simd_threshold.sv
// Self-checking bench for double_simd_threshold: reset, idle input, boundary
// lanes, full frames with and without random backpressure, and restart.
module tb_double_simd_threshold;

  localparam int WIDTH  = 64;
  localparam int HEIGHT = 64;
  localparam int SIMD   = 4;
  localparam int THRESH = 128;
  localparam int BPR    = WIDTH / SIMD;
  localparam int BEATS  = BPR * HEIGHT;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_errors = 0;

  logic [8*SIMD-1:0] px       [BEATS];
  logic [8*SIMD-1:0] prev_out [BEATS];

  double_simd_threshold_if #(.SIMD_WIDTH(SIMD)) bus_if ();

  double_simd_threshold #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SIMD_WIDTH(SIMD), .THRESHOLD(THRESH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each lane becomes 255 when strictly above the threshold, else 0.
  function automatic logic [8*SIMD-1:0] thr_model(input logic [8*SIMD-1:0] beat);
    logic [8*SIMD-1:0] r;
    int p;
    r = '0;
    for (int k = 0; k < SIMD; k++) begin
      p = int'(beat[8*k +: 8]);
      r[8*k +: 8] = (p > THRESH) ? 8'd255 : 8'd0;
    end
    return r;
  endfunction

  task automatic run_frame(input bit rand_px, input bit bp, input bit mid_start, input bit cmp_prev);
    logic [8*SIMD-1:0] exp_q  [$];
    logic [1:0]        flag_q [$];
    logic [8*SIMD-1:0] held;
    logic [8*SIMD-1:0] e;
    logic [1:0]        f;
    bit stalled;
    int sent, recv, cyc;

    // Build the frame in raster order.
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < SIMD; k++) begin
        int r, c;
        r = b / BPR;
        c = (b % BPR) * SIMD + k;
        px[b][8*k +: 8] = rand_px ? 8'($urandom) : 8'((r + c) & 255);
      end
    end

    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held = '0;

    start = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done_clear", done, 1'b0);

    while (recv < BEATS && cyc < 20000) begin
      bus_if.in_valid  = (sent < BEATS) && (!bp || $urandom_range(0, 3) != 0);
      bus_if.in_data   = (sent < BEATS) ? px[sent] : '0;
      bus_if.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start            = mid_start && (sent == 5);
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", bus_if.out_valid, 1'b1);
        check("stall_data", bus_if.out_data, held);
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        exp_q.push_back(thr_model(px[sent]));
        flag_q.push_back({(sent % BPR) == BPR - 1, sent == BEATS - 1});
        sent++;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          f = flag_q.pop_front();
          check("beat_data", bus_if.out_data, e);
          check("beat_eol_eof", {bus_if.out_eol, bus_if.out_eof}, f);
          if (f[0]) check("done_early", done, 1'b0);
          if (cmp_prev) check("restart_same", bus_if.out_data, prev_out[recv]);
          prev_out[recv] = bus_if.out_data;
        end
        recv++;
      end
      stalled = bus_if.out_valid && !bus_if.out_ready;
      held    = bus_if.out_data;
      @(posedge clk); #1;
      cyc++;
    end

    start = 1'b0;
    bus_if.in_valid = 1'b0;
    check("beat_count", recv, BEATS);
    check("frame_done", done, 1'b1);
    check("frame_idle", busy, 1'b0);
    check("frame_in_ready", bus_if.in_ready, 1'b0);
    check("frame_out_valid", bus_if.out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_out_data", bus_if.out_data, '0);
    check("rst_flags", {bus_if.out_eol, bus_if.out_eof}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", bus_if.in_ready, 1'b0);

    // Input offered while idle must be dropped.
    @(posedge clk); #1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = '1;
    bus_if.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_in_ready", bus_if.in_ready, 1'b0);
      check("idle_out_valid", bus_if.out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Boundary lanes {129,128,255,0}, one-cycle latency.
    bus_if.in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h8180FF00;
    @(negedge clk);
    check("bnd_in_ready", bus_if.in_ready, 1'b1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("bnd_out_valid", bus_if.out_valid, 1'b1);
    check("bnd_out_data", bus_if.out_data, 32'hFF00FF00);
    check("bnd_flags", {bus_if.out_eol, bus_if.out_eof}, 2'b00);

    // Reset mid-stream with a stalled beat in the output register.
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 32'h01020304;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_stall", bus_if.out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", bus_if.out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_in_ready", bus_if.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", bus_if.out_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Full ramp frame with a start pulse mid-frame, then restart with same input.
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("done_held", done, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Random pixels with random backpressure on both sides.
    @(posedge clk); #1;
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
